// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the decade stopwatch controller.
package stopwatch_pkg;

   localparam int unsigned BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } sw_state_t;

   // Value a BCD digit takes after one increment (9 wraps to 0).
   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] q);
      return (q == BCD_MAX) ? '0 : q + BCD_W'(1);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade counter stage; carry is high when this stage wraps on the current edge.
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic             x,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [BCD_W-1:0] q,
   output logic             carry
);

   // Digit register: clear wins over increment.
   always_ff @(posedge x) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= bcd_inc(q);
      end
   end

   assign carry = en & (q == BCD_MAX);

endmodule

// File: rtl/decade_stopwatch_ctrl.sv
// Start/stop/lap/clear sequencer for a two-digit BCD stopwatch with lap-freeze display.
module decade_stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned PRESCALE = 10
) (
   input  logic             x,
   input  logic             reset,
   input  logic             start_stop,
   input  logic             lap,
   input  logic             clear,
   output logic             run,
   output logic [1:0]       state,
   output logic             tick,
   output logic             rollover,
   output logic [BCD_W-1:0] ones,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] disp_ones,
   output logic [BCD_W-1:0] disp_tens
);

   localparam int unsigned P_W = $clog2(PRESCALE);
   localparam logic [P_W-1:0] P_LAST = P_W'(PRESCALE - 1);

   sw_state_t        state_r;
   sw_state_t        state_nxt;
   logic             clr_c;
   logic             counting;
   logic             adv;
   logic [P_W-1:0]   p_r;
   logic [P_W-1:0]   p_nxt;
   logic             ones_carry;
   logic             tens_carry;
   logic [BCD_W-1:0] ones_nxt;
   logic [BCD_W-1:0] tens_nxt;
   logic             disp_load;

   // State register.
   always_ff @(posedge x) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state decode; clear beats start_stop, start_stop beats lap.
   always_comb begin
      state_nxt = state_r;
      clr_c     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (clear) begin
               clr_c = 1'b1;
            end else if (start_stop) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (start_stop) begin
               state_nxt = ST_PAUSE;
            end else if (lap) begin
               state_nxt = ST_LAP;
            end
         end
         ST_LAP: begin
            if (start_stop) begin
               state_nxt = ST_PAUSE;
            end else if (lap) begin
               state_nxt = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (clear) begin
               clr_c     = 1'b1;
               state_nxt = ST_IDLE;
            end else if (start_stop) begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Prescaler, next digit values and display load enable.
   always_comb begin
      counting  = (state_r == ST_RUN) || (state_r == ST_LAP);
      adv       = counting && (p_r == P_LAST);
      p_nxt     = p_r;
      if (clr_c || (state_r == ST_IDLE)) begin
         p_nxt = '0;
      end else if (counting) begin
         p_nxt = adv ? '0 : p_r + P_W'(1);
      end
      ones_nxt  = clr_c ? '0 : (adv ? bcd_inc(ones) : ones);
      tens_nxt  = clr_c ? '0 : (ones_carry ? bcd_inc(tens) : tens);
      disp_load = (state_nxt != ST_LAP) || (state_r != ST_LAP);
   end

   bcd_digit u_ones (
      .x     (x),
      .reset (reset),
      .clr   (clr_c),
      .en    (adv),
      .q     (ones),
      .carry (ones_carry)
   );

   bcd_digit u_tens (
      .x     (x),
      .reset (reset),
      .clr   (clr_c),
      .en    (ones_carry),
      .q     (tens),
      .carry (tens_carry)
   );

   // Prescaler count, event pulses, run flag and display registers.
   always_ff @(posedge x) begin
      if (reset) begin
         p_r       <= '0;
         tick      <= 1'b0;
         rollover  <= 1'b0;
         run       <= 1'b0;
         disp_ones <= '0;
         disp_tens <= '0;
      end else begin
         p_r      <= p_nxt;
         tick     <= adv;
         rollover <= tens_carry;
         run      <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
         if (disp_load) begin
            disp_ones <= ones_nxt;
            disp_tens <= tens_nxt;
         end
      end
   end

   assign state = state_r;

endmodule

// File: tb/tb_decade_stopwatch_ctrl.sv
// Bench for decade_stopwatch_ctrl: table vectors, corner sequences, random commands vs. a count model.
module tb_decade_stopwatch_ctrl;

   localparam int PRE = 10;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

   logic       x;
   logic       reset, start_stop, lap, clear;
   logic       run, tick, rollover;
   logic [1:0] state;
   logic [3:0] ones, tens, disp_ones, disp_tens;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: whole count as an integer 0..99.
   int m_state = 0, m_p = 0, m_cnt = 0, m_disp = 0;
   bit m_tick = 0, m_roll = 0, m_run = 0;

   decade_stopwatch_ctrl #(.PRESCALE(PRE)) dut (
      .x          (x),
      .reset      (reset),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .run        (run),
      .state      (state),
      .tick       (tick),
      .rollover   (rollover),
      .ones       (ones),
      .tens       (tens),
      .disp_ones  (disp_ones),
      .disp_tens  (disp_tens)
   );

   initial x = 1'b0;
   always #5 x = ~x;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic s, input logic l, input logic c);
      int  ns;
      bit  adv, clr;
      if (r) begin
         m_state = S_IDLE; m_p = 0; m_cnt = 0; m_disp = 0;
         m_tick = 0; m_roll = 0; m_run = 0;
         return;
      end
      adv = 0; clr = 0; ns = m_state;
      if (m_state == S_RUN || m_state == S_LAP) begin
         if (m_p == PRE - 1) begin m_p = 0; adv = 1; end
         else m_p++;
      end else if (m_state == S_IDLE) begin
         m_p = 0;
      end
      case (m_state)
         S_IDLE:  if (c) clr = 1; else if (s) ns = S_RUN;
         S_RUN:   if (s) ns = S_PAUSE; else if (l) ns = S_LAP;
         S_LAP:   if (s) ns = S_PAUSE; else if (l) ns = S_RUN;
         default: if (c) begin clr = 1; ns = S_IDLE; end else if (s) ns = S_RUN;
      endcase
      m_roll = adv && (m_cnt == 99);
      if (adv) m_cnt = (m_cnt + 1) % 100;
      if (clr) begin m_cnt = 0; m_p = 0; end
      if (!(ns == S_LAP && m_state == S_LAP)) m_disp = m_cnt;
      m_tick  = adv;
      m_run   = (ns == S_RUN) || (ns == S_LAP);
      m_state = ns;
   endtask

   function automatic logic [31:0] dut_vec();
      return 32'({state, run, tick, rollover, tens, ones, disp_tens, disp_ones});
   endfunction

   function automatic logic [31:0] model_vec();
      logic [1:0] st;
      logic [3:0] t, o, dt, d_o;
      st = 2'(m_state); t = 4'(m_cnt / 10); o = 4'(m_cnt % 10);
      dt = 4'(m_disp / 10); d_o = 4'(m_disp % 10);
      return 32'({st, m_run, m_tick, m_roll, t, o, dt, d_o});
   endfunction

   function automatic logic [31:0] dut_cnt();
      return 32'(tens) * 10 + 32'(ones);
   endfunction

   function automatic logic [31:0] dut_disp();
      return 32'(disp_tens) * 10 + 32'(disp_ones);
   endfunction

   // One clock edge with the given command inputs, then a full compare against the model.
   task automatic step(input logic r, input logic s, input logic l, input logic c);
      reset = r; start_stop = s; lap = l; clear = c;
      @(posedge x);
      model_edge(r, s, l, c);
      #1;
      reset = 0; start_stop = 0; lap = 0; clear = 0;
      check("model", dut_vec(), model_vec());
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   typedef struct {
      logic rst, ss, lp, clr;
      int   idle;
      int   st, cnt, disp;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int n_ticks, first_tick, last_tick, bad_gap, n_roll, roll_at, cnt_mid;

      reset = 1; start_stop = 0; lap = 0; clear = 0;

      vecs[0]  = '{1, 0, 0, 0,   0, S_IDLE,   0,  0};
      vecs[1]  = '{0, 1, 0, 0, 100, S_RUN,   10, 10};
      vecs[2]  = '{0, 0, 1, 0,   0, S_LAP,   10, 10};
      vecs[3]  = '{0, 0, 0, 0,  39, S_LAP,   14, 10};
      vecs[4]  = '{0, 0, 1, 0,   0, S_RUN,   14, 14};
      vecs[5]  = '{0, 1, 0, 0,   0, S_PAUSE, 14, 14};
      vecs[6]  = '{0, 0, 0, 0,  49, S_PAUSE, 14, 14};
      vecs[7]  = '{0, 1, 0, 1,   0, S_IDLE,   0,  0};
      vecs[8]  = '{0, 1, 0, 1,   5, S_IDLE,   0,  0};
      vecs[9]  = '{0, 1, 0, 0,   9, S_RUN,    0,  0};
      vecs[10] = '{0, 0, 0, 1,   0, S_RUN,    1,  1};
      vecs[11] = '{0, 1, 1, 0,   0, S_PAUSE,  1,  1};
      vecs[12] = '{0, 0, 1, 0,   0, S_PAUSE,  1,  1};

      step(1, 0, 0, 0);
      for (int i = 0; i < 13; i++) begin
         step(vecs[i].rst, vecs[i].ss, vecs[i].lp, vecs[i].clr);
         run_n(vecs[i].idle);
         check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
         check($sformatf("vec%0d_count", i), dut_cnt(), 32'(vecs[i].cnt));
         check($sformatf("vec%0d_disp", i), dut_disp(), 32'(vecs[i].disp));
      end

      // Tick spacing: first tick on the 10th edge, then every 10 edges.
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      n_ticks = 0; first_tick = -1; last_tick = -1; bad_gap = 0;
      for (int i = 0; i < 100; i++) begin
         step(0, 0, 0, 0);
         if (tick) begin
            n_ticks++;
            if (first_tick < 0) first_tick = i;
            else if (i - last_tick != PRE) bad_gap++;
            last_tick = i;
         end
      end
      check("tick_count", 32'(n_ticks), 32'd10);
      check("tick_first", 32'(first_tick), 32'(PRE - 1));
      check("tick_gap", 32'(bad_gap), 32'd0);
      check("count_100", dut_cnt(), 32'd10);

      // 98 -> 99 -> 00 with a single rollover on the wrap edge.
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      run_n(980);
      check("at_98", dut_cnt(), 32'd98);
      n_roll = 0; roll_at = -1; cnt_mid = -1;
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 0, 0);
         if (i == 9) cnt_mid = int'(dut_cnt());
         if (rollover) begin n_roll++; roll_at = i; end
      end
      check("at_99", 32'(cnt_mid), 32'd99);
      check("roll_count", 32'(n_roll), 32'd1);
      check("roll_edge", 32'(roll_at), 32'd19);
      check("wrap_00", dut_cnt(), 32'd0);

      // Lap freeze at 23 while live count reaches 27, then unfreeze.
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      run_n(230);
      step(0, 0, 1, 0);
      run_n(39);
      check("lap_live", dut_cnt(), 32'd27);
      check("lap_disp", dut_disp(), 32'd23);
      step(0, 0, 1, 0);
      check("unlap_disp", dut_disp(), 32'd27);
      check("unlap_state", 32'(state), 32'(S_RUN));

      // Pause at 42 with p=4, hold, resume -> 43 after 6 edges, then clear.
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      run_n(423);
      step(0, 1, 0, 0);
      run_n(50);
      check("pause_hold", dut_cnt(), 32'd42);
      step(0, 1, 0, 0);
      run_n(5);
      check("resume_5", dut_cnt(), 32'd42);
      step(0, 0, 0, 0);
      check("resume_6", dut_cnt(), 32'd43);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      check("clear_all", dut_vec(), 32'd0);

      // Reset held mid-run at 57 with every command asserted.
      step(0, 1, 0, 0);
      run_n(570);
      check("at_57", dut_cnt(), 32'd57);
      step(1, 1, 1, 1);
      check("reset_1", dut_vec(), 32'd0);
      step(1, 1, 1, 1);
      check("reset_2", dut_vec(), 32'd0);
      step(0, 0, 0, 0);
      check("post_reset", dut_vec(), 32'd0);

      // Random commands against the model.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 19) == 0,  $urandom_range(0, 14) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
